// File: rtl/mx_block_sequencer_if.sv
// mx_block_sequencer_if: element input stream plus scaled element output stream for the MX block sequencer
interface mx_block_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int IDX_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [EXP_W-1:0]  out_scale;
  logic              out_last;
  logic [IDX_W-1:0]  out_idx;
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_scale, out_last, out_idx
  );
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_scale, out_last, out_idx
  );
endinterface

// File: rtl/mx_block_sequencer.sv
// mx_block_sequencer: buffers one FP32 block, derives its shared MX scale, replays elements with the scale (MX_NAN_PROPAGATE_EN forces scale 0xFF on an exp==0xFF element)
module mx_block_sequencer #(
  parameter int BLOCK_SIZE = 32,
  parameter int DATA_W     = 32,
  parameter int EXP_W      = 8
) (
  input logic clk,
  input logic rst,
  mx_block_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(BLOCK_SIZE);
  typedef enum logic [1:0] {COLLECT, SCALE, EMIT} state_t;
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  count_q, count_d, idx_q, idx_d, idx_n;
  logic [EXP_W-1:0]  max_q, max_d, scale_q, scale_d, exp_in, exp_eff;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] buf_q [BLOCK_SIZE];
  logic [DATA_W-1:0] buf_d [BLOCK_SIZE];
  logic              valid_q, valid_d, last_q, last_d;
  logic              acc, fire, do_flush, nan;
  logic [IDX_W:0]    fill;
  assign bus.in_ready  = (state_q == COLLECT) & ~rst;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_scale = scale_q;
  assign bus.out_last  = last_q;
  assign bus.out_idx   = idx_q;
  assign exp_in  = bus.in_data[DATA_W-2 -: EXP_W];
  assign exp_eff = exp_in == '0 ? EXP_W'(1) : exp_in;
  assign acc     = bus.in_valid & bus.in_ready;
  assign fire    = valid_q & bus.out_ready;
  assign fill    = {1'b0, count_q} + {{IDX_W{1'b0}}, acc};
  assign do_flush = (state_q == COLLECT) & bus.flush & (fill != '0);
  assign idx_n   = idx_q + IDX_W'(1);
`ifdef MX_NAN_PROPAGATE_EN
  logic nan_q, nan_d;
  assign nan_d = (state_q == EMIT && fire && last_q) ? 1'b0 : nan_q | (acc & (&exp_in));
  always_ff @(posedge clk)
    nan_q <= rst ? 1'b0 : nan_d;
  assign nan = nan_q;
`else
  assign nan = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    count_d = acc ? count_q + IDX_W'(1) : count_q;
    max_d   = (acc && exp_eff > max_q) ? exp_eff : max_q;
    idx_d   = idx_q;
    scale_d = scale_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    // stored element wins its slot; flush zero-pads every slot after it (pads add e'=1, never above max)
    for (int i = 0; i < BLOCK_SIZE; i++)
      buf_d[i] = (acc && count_q == IDX_W'(i)) ? bus.in_data :
                 (do_flush && fill <= (IDX_W+1)'(i)) ? '0 : buf_q[i];
    unique case (state_q)
      COLLECT: if (fill == (IDX_W+1)'(BLOCK_SIZE) || do_flush) begin
        state_d = SCALE;
        count_d = '0;
      end
      SCALE: begin
        state_d = EMIT;
        scale_d = nan ? '1 : max_q;
        idx_d   = '0;
        data_d  = buf_q[0];
        valid_d = 1'b1;
        last_d  = 1'b0;
      end
      EMIT: if (fire) begin
        if (last_q) begin
          state_d = COLLECT;
          valid_d = 1'b0;
          last_d  = 1'b0;
          idx_d   = '0;
          max_d   = EXP_W'(1);
        end else begin
          idx_d  = idx_n;
          data_d = buf_q[idx_n];
          last_d = idx_n == IDX_W'(BLOCK_SIZE - 1);
        end
      end
      default: state_d = COLLECT;
    endcase
  end
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (rst) begin
      state_q <= COLLECT;
      count_q <= '0;
      max_q   <= EXP_W'(1);
      idx_q   <= '0;
      scale_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      scale_q <= scale_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_mx_block_sequencer.sv
// tb_mx_block_sequencer: directed blocks with a scoreboard of expected beats checked by an independent monitor
module tb_mx_block_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mx_block_sequencer_if #(.DATA_W(32), .EXP_W(8), .IDX_W(5)) bus ();
  mx_block_sequencer #(.BLOCK_SIZE(32), .DATA_W(32), .EXP_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  s;
    logic [4:0]  i;
    logic        l;
  } beat_t;
  beat_t       q[$];
  logic [31:0] blk [32];
  int          n_chk = 0, n_fail = 0, cyc = 0, ev_cyc = 0, cnt = 0;
  logic        busy = 0, stall = 0, pv = 0, rst_p, rdy_mode = 0;
  beat_t       held;
  always @(posedge clk) begin
    cyc++;
    rst_p <= rst;
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    beat_t got, exp_b;
    got = {bus.out_data, bus.out_scale, bus.out_idx, bus.out_last};
    if (rst) begin
      if (rst_p) check("reset_values", {got, bus.out_valid, bus.in_ready}, 64'h0);
      cnt = 0; busy = 0; stall = 0; pv = 0;
    end else begin
      if (stall) check("hold_stable", {got, bus.out_valid}, {held, 1'b1});
      if (bus.out_valid && !pv) check("first_valid_latency", 64'(cyc - ev_cyc), 64'd2);
      if (busy) check("in_ready_low", 64'(bus.in_ready), 64'd0);
      if (bus.in_valid && bus.in_ready) begin cnt++; ev_cyc = cyc; end
      if ((bus.flush && bus.in_ready && cnt > 0) || cnt == 32) begin busy = 1; cnt = 0; ev_cyc = cyc; end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_beat: got idx %0d expected no beat", bus.out_idx);
        end else begin
          exp_b = q.pop_front();
          check($sformatf("beat_idx%0d", exp_b.i), 64'(got), 64'(exp_b));
        end
        if (bus.out_last) busy = 0;
      end
      stall = bus.out_valid & ~bus.out_ready;
      held  = got;
      pv    = bus.out_valid;
    end
  end
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rdy_mode ? (cyc % 3 != 0 && $urandom_range(0, 1) == 1) || (cyc % 3 == 1) : 1'b1;
    end
  end
  task automatic push_elem(input logic v, input logic [31:0] d, input logic f);
    logic ok;
    bus.in_valid = v; bus.in_data = d; bus.flush = f;
    for (int t = 0; ; t++) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
      if (ok) break;
      if (t > 500) begin
        n_chk++; n_fail++;
        $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 500 cycles");
        break;
      end
    end
    bus.in_valid = 1'b0; bus.flush = 1'b0;
  endtask
  task automatic run_block(input int n, input int fl_mode, input logic [7:0] scale);
    for (int i = 0; i < 32; i++)
      q.push_back('{d: (i < n) ? blk[i] : 32'h0, s: scale, i: 5'(i), l: (i == 31)});
    for (int i = 0; i < n; i++) push_elem(1'b1, blk[i], fl_mode == 2 && i == n - 1);
    if (fl_mode == 1) push_elem(1'b0, 32'h0, 1'b1);
  endtask
  task automatic fill_blk(input logic [31:0] v);
    for (int i = 0; i < 32; i++) blk[i] = v;
  endtask
  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    fill_blk(32'h3F800000); run_block(32, 0, 8'h7F);
    blk[17] = 32'h41000000; run_block(32, 0, 8'h82);
    fill_blk(32'h00000000); run_block(32, 0, 8'h01);
    fill_blk(32'h40000000); run_block(5, 1, 8'h80);
    fill_blk(32'h40800000); run_block(3, 2, 8'h81);
    rdy_mode = 1'b1;
    for (int i = 0; i < 32; i++) blk[i] = {1'b0, 8'(8'h70 + i % 8), 23'(i)};
    blk[3] = 32'hBD000000;
    run_block(32, 0, 8'h7A);
    for (int t = 0; t < 2000 && q.size() != 0; t++) @(posedge clk);
    rdy_mode = 1'b0;
    for (int i = 0; i < 10; i++) push_elem(1'b1, 32'h41000000, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    fill_blk(32'h3F800000); blk[0] = 32'h3F800001; run_block(32, 0, 8'h7F);
    fill_blk(32'h3F800000); blk[9] = 32'h7FC00000; run_block(32, 0, 8'hFF);
    for (int t = 0; t < 2000 && q.size() != 0; t++) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats outstanding expected 0", q.size());
    end
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
